// File: rtl/fir_decim_mac4.sv
// ---------------------------------------------------------------------------
// fir_decim_mac4
//
// Decimating FIR engine that sits directly behind a 4-bank 256x16 sample RAM.
// It owns both RAM ports:
//  - Write side: incoming samples are written circularly at a wrapping write
//    pointer (wp).
//  - Read side: the engine reads four consecutive samples per cycle.
// Every DECIM accepted samples it sweeps the NTAPS newest samples in NTAPS/4
// cycles. Each sweep cycle does four 16x16 MACs, and each sweep emits one
// saturated output.
//
// Build option:
//   FIR_ROUND_EN  when defined, the accumulator starts at 1<<(OUT_SHIFT-1).
//                 The final shift then rounds half up instead of truncating.
//
// Handshake: there is no backpressure anywhere. Each cycle with in_valid=1 is
// exactly one accepted sample. out_valid is a one-cycle pulse, and out_data
// holds its value until the next pulse.
//
// Ports:
//   clock, reset_n             clock (rising edge), async active-low reset
//   in_valid, in_data          input sample strobe and signed sample
//   ram_data, ram_wraddress,   RAM write port (data/enable combinational,
//   ram_wren                   address = wp register)
//   ram_rdaddress              registered RAM read base address
//   ram_q0..ram_q3             samples at rdaddress+0..+3, one cycle later
//   coef_addr                  registered coefficient group index k
//   coef_q0..coef_q3           coefficients 4k+0..4k+3, one cycle later
//   out_valid, out_data        output pulse and signed filtered sample
//   overrun                    sticky: trigger arrived while busy
//   dbg_state                  current FSM state (0 idle, 1 run, 2 drain)
// ---------------------------------------------------------------------------
module fir_decim_mac4 #(
    parameter int NTAPS     = 64,
    parameter int DECIM     = 8,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic signed [15:0] in_data,
    output logic        [15:0] ram_data,
    output logic        [7:0]  ram_wraddress,
    output logic               ram_wren,
    output logic        [7:0]  ram_rdaddress,
    input  logic signed [15:0] ram_q0,
    input  logic signed [15:0] ram_q1,
    input  logic signed [15:0] ram_q2,
    input  logic signed [15:0] ram_q3,
    output logic        [5:0]  coef_addr,
    input  logic signed [15:0] coef_q0,
    input  logic signed [15:0] coef_q1,
    input  logic signed [15:0] coef_q2,
    input  logic signed [15:0] coef_q3,
    output logic               out_valid,
    output logic signed [15:0] out_data,
    output logic               overrun,
    output logic        [1:0]  dbg_state
);

    localparam int G   = NTAPS / 4;
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [ACC_W-1:0] SAT_HI = 32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -32768;

`ifdef FIR_ROUND_EN
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W-1:0] ACC_INIT =
        (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
`else
    localparam logic signed [ACC_W-1:0] ACC_INIT = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]     wp;
    logic [DCW-1:0] decim_cnt;
    logic [7:0]     fill_cnt;
    logic [1:0]     drain_cnt;

    logic busy, run_act, last_grp;
    logic trig, trig_ok, start, ovr_set;

    // The MAC pipeline follows the sweep with one flag per stage:
    //   v1/l1  RAM and coefficient data are on the inputs
    //   v2/l2  products are registered
    //   l3     the accumulator holds the final sum
    logic v1, v2, l1, l2, l3;
    logic signed [31:0]      p0, p1, p2, p3;
    logic signed [ACC_W-1:0] acc, psum, shifted;
    logic signed [15:0]      sat_val;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [31:0] v);
        return {{(ACC_W-32){v[31]}}, v};
    endfunction

    // Write port: data and enable pass straight through, address is wp.
    assign ram_data      = in_data;
    assign ram_wren      = in_valid;
    assign ram_wraddress = wp;
    assign dbg_state     = state;

    // A trigger is the sample that completes a decimation period.
    // The comparison counts the trigger sample itself toward the fill
    // requirement.
    assign trig    = in_valid && (decim_cnt == DCW'(DECIM - 1));
    assign trig_ok = trig && (fill_cnt >= 8'(NTAPS - 1));
    assign start   = trig_ok && !busy;
    assign ovr_set = trig_ok && busy;

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)           state_nxt = S_RUN;
            S_RUN:   if (last_grp)        state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd2) state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = 1'b0;
        run_act  = 1'b0;
        last_grp = 1'b0;
        case (state)
            S_RUN: begin
                busy     = 1'b1;
                run_act  = 1'b1;
                last_grp = (coef_addr == 6'(G - 1));
            end
            S_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // Sample bookkeeping: write pointer, decimation phase and fill count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            decim_cnt <= '0;
            fill_cnt  <= '0;
        end else if (in_valid) begin
            wp        <= wp + 8'd1;
            decim_cnt <= (decim_cnt == DCW'(DECIM - 1)) ? '0 : decim_cnt + DCW'(1);
            if (fill_cnt < 8'(NTAPS)) fill_cnt <= fill_cnt + 8'd1;
        end
    end

    // Sweep address generation.
    // The base address is the oldest sample of the window, i.e. NTAPS-1
    // behind the sample that is being written in the trigger cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_rdaddress <= '0;
            coef_addr     <= '0;
            drain_cnt     <= '0;
            overrun       <= 1'b0;
        end else begin
            if (start) begin
                ram_rdaddress <= wp - 8'(NTAPS - 1);
                coef_addr     <= '0;
            end else if (run_act && !last_grp) begin
                ram_rdaddress <= ram_rdaddress + 8'd4;
                coef_addr     <= coef_addr + 6'd1;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (ovr_set) overrun <= 1'b1;
        end
    end

    assign psum = sext(p0) + sext(p1) + sext(p2) + sext(p3);

    // MAC pipeline: products, then accumulate, then shift/saturate to output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            l3        <= 1'b0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            v1 <= run_act;
            l1 <= last_grp;
            v2 <= v1;
            l2 <= l1;
            l3 <= l2;
            if (v1) begin
                p0 <= ram_q0 * coef_q0;
                p1 <= ram_q1 * coef_q1;
                p2 <= ram_q2 * coef_q2;
                p3 <= ram_q3 * coef_q3;
            end
            if (start)   acc <= ACC_INIT;
            else if (v2) acc <= acc + psum;
            out_valid <= l3;
            if (l3) out_data <= sat_val;
        end
    end

    // Arithmetic shift (floor), then clamp to the 16-bit signed range.
    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        if (shifted > SAT_HI)      sat_val = 16'sh7fff;
        else if (shifted < SAT_LO) sat_val = 16'sh8000;
        else                       sat_val = shifted[15:0];
    end

endmodule
